// File: rtl/hub75_scan_driver_if.sv
// rtl/hub75_scan_driver_if.sv - pixel-write, swap and panel-drive bundle for hub75_scan_driver
//
// master: host side (game/menu logic drives writes and swap requests, sees panel pins)
// slave : scan driver side
//   wr_en/wr_x/wr_y/wr_rgb : one back-buffer pixel write per cycle
//   swap_req/swap_ack      : tear-free front/back swap request and acknowledge pulse
//   blank                  : force panel dark
//   rgb/outclk/lat/oe/abc  : HUB75 panel pins
//   frame_done             : end-of-frame pulse
interface hub75_scan_driver_if #(
    parameter int COLS = 32,
    parameter int ROWS = 16,
    parameter int BPC  = 2
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int AW = $clog2(ROWS / 2);

    logic             wr_en;
    logic [XW-1:0]    wr_x;
    logic [YW-1:0]    wr_y;
    logic [3*BPC-1:0] wr_rgb;
    logic             swap_req;
    logic             blank;
    logic [5:0]       rgb;
    logic             outclk;
    logic             lat;
    logic             oe;
    logic [AW-1:0]    abc;
    logic             swap_ack;
    logic             frame_done;

    modport master (
        output wr_en, wr_x, wr_y, wr_rgb, swap_req, blank,
        input  rgb, outclk, lat, oe, abc, swap_ack, frame_done
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_rgb, swap_req, blank,
        output rgb, outclk, lat, oe, abc, swap_ack, frame_done
    );
endinterface

// File: rtl/hub75_scan_driver.sv
// rtl/hub75_scan_driver.sv - HUB75 scan driver with double-buffered framebuffer and BCM colour depth
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : hub75_scan_driver_if.slave (pixel writes, swap handshake, blank, panel pins)
//
// Scans two lines at a time (top/bottom halves); each line is shown as BPC bit planes,
// plane b lit for SHOW_BASE<<b cycles. Each buffer is split into a top and a bottom bank so
// one synchronous read per bank yields the pixel pair for the current column.
module hub75_scan_driver #(
    parameter int COLS      = 32,
    parameter int ROWS      = 16,
    parameter int BPC       = 2,
    parameter int SHOW_BASE = 8
) (
    input  logic               clk,
    input  logic               reset,
    hub75_scan_driver_if.slave bus
);
    localparam int XW       = $clog2(COLS);
    localparam int YW       = $clog2(ROWS);
    localparam int RW       = YW - 1;
    localparam int BW       = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int PW       = 3 * BPC;
    localparam int SHOW_MAX = SHOW_BASE << (BPC - 1);
    localparam int CMAX     = (2 * COLS > SHOW_MAX) ? 2 * COLS : SHOW_MAX;
    localparam int CW       = $clog2(CMAX);
    localparam int AW       = 1 + RW + XW;
    localparam int DEPTH    = 1 << AW;

    typedef enum logic [1:0] {
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_SHOW
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [BW-1:0] b_q, b_d;
    logic [RW-1:0] r_q, r_d;
    logic [RW-1:0] abc_q, abc_d;
    logic          front_q, front_d;
    logic          pending_q, pending_d;
    // Low for the single prefetch cycle after reset: counters hold while the first
    // pixel pair is read, and the panel outputs stay at their idle values.
    logic          started_q, started_d;

    logic [PW-1:0] mem_top [DEPTH];
    logic [PW-1:0] mem_bot [DEPTH];
    logic [PW-1:0] rd_top_q, rd_top_d;
    logic [PW-1:0] rd_bot_q, rd_bot_d;

    logic [CW-1:0] show_last;
    logic          frame_last;
    logic          swap_ack;
    logic          wr_ok;
    logic          wr_bot;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    logic [BPC-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;
    logic [5:0]     rgb_o;
    logic           outclk_o, lat_o, oe_o;

    assign show_last = CW'((SHOW_BASE << b_q) - 1);

    // Scan sequencer: SHIFT -> BLANK -> LATCH -> SHOW per bit plane, planes inside rows.
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        b_d        = b_q;
        r_d        = r_q;
        abc_d      = abc_q;
        started_d  = 1'b1;
        frame_last = 1'b0;
        if (started_q) begin
            case (state_q)
                ST_SHIFT: begin
                    if (c_q == CW'(2 * COLS - 1)) begin
                        c_d     = '0;
                        abc_d   = r_q;
                        state_d = ST_BLANK;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                ST_BLANK: state_d = ST_LATCH;
                ST_LATCH: state_d = ST_SHOW;
                ST_SHOW: begin
                    if (c_q == show_last) begin
                        c_d     = '0;
                        state_d = ST_SHIFT;
                        if (b_q == BW'(BPC - 1)) begin
                            b_d        = '0;
                            r_d        = r_q + 1'b1;
                            frame_last = (r_q == RW'(ROWS / 2 - 1));
                        end else begin
                            b_d = b_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                default: state_d = ST_SHIFT;
            endcase
        end
    end

    // Swap takes effect on the last cycle of a frame; a same-cycle request counts.
    assign swap_ack = frame_last & (pending_q | bus.swap_req);

    always_comb begin
        front_d   = front_q ^ swap_ack;
        pending_d = swap_ack ? 1'b0 : (pending_q | bus.swap_req);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SHIFT;
            c_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            abc_q     <= '0;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            b_q       <= b_d;
            r_q       <= r_d;
            abc_q     <= abc_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            started_q <= started_d;
        end
    end

    // Writes always go to the buffer that is not being scanned right now.
    assign wr_ok   = bus.wr_en && (int'(bus.wr_x) < COLS) && (int'(bus.wr_y) < ROWS);
    assign wr_bot  = bus.wr_y[YW-1];
    assign wr_addr = {~front_q, bus.wr_y[RW-1:0], bus.wr_x};

    always_ff @(posedge clk) begin
        if (wr_ok && !wr_bot) begin
            mem_top[wr_addr] <= bus.wr_rgb;
        end
        if (wr_ok && wr_bot) begin
            mem_bot[wr_addr] <= bus.wr_rgb;
        end
    end

    // Read one cycle ahead using next-state coordinates so rgb is ready on the first
    // cycle of each pixel. On the swap edge the write lands in the buffer being read,
    // so that write is forwarded straight into the read register.
    assign rd_addr = {front_d, r_d, c_d[XW:1]};

    always_comb begin
        rd_top_d = (wr_ok && !wr_bot && (wr_addr == rd_addr)) ? bus.wr_rgb : mem_top[rd_addr];
        rd_bot_d = (wr_ok &&  wr_bot && (wr_addr == rd_addr)) ? bus.wr_rgb : mem_bot[rd_addr];
    end

    always_ff @(posedge clk) begin
        rd_top_q <= rd_top_d;
        rd_bot_q <= rd_bot_d;
    end

    assign {top_r, top_g, top_b} = rd_top_q;
    assign {bot_r, bot_g, bot_b} = rd_bot_q;

    always_comb begin
        rgb_o    = '0;
        outclk_o = 1'b0;
        lat_o    = 1'b0;
        oe_o     = 1'b1;
        if (started_q) begin
            case (state_q)
                ST_SHIFT: begin
                    outclk_o = c_q[0];
                    rgb_o    = {top_r[b_q], top_g[b_q], top_b[b_q],
                                bot_r[b_q], bot_g[b_q], bot_b[b_q]};
                end
                ST_LATCH: lat_o = 1'b1;
                ST_SHOW:  oe_o  = bus.blank;
                default:  ;
            endcase
        end
    end

    assign bus.rgb        = rgb_o;
    assign bus.outclk     = outclk_o;
    assign bus.lat        = lat_o;
    assign bus.oe         = oe_o;
    assign bus.abc        = abc_q;
    assign bus.swap_ack   = swap_ack;
    assign bus.frame_done = frame_last;
endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb/tb_hub75_scan_driver.sv - self-checking bench for hub75_scan_driver
module tb_hub75_scan_driver;
    localparam int COLS      = 32;
    localparam int ROWS      = 16;
    localparam int BPC       = 2;
    localparam int SHOW_BASE = 8;
    localparam int HALF      = ROWS / 2;
    localparam int XW        = $clog2(COLS);
    localparam int YW        = $clog2(ROWS);
    localparam int AW        = $clog2(HALF);
    localparam int PLANE0    = 2 * COLS + 2 + SHOW_BASE;
    localparam int ROW_LEN   = BPC * (2 * COLS + 2) + SHOW_BASE * ((1 << BPC) - 1);
    localparam int FRAME     = HALF * ROW_LEN;
    localparam int FRAME2    = 16 * (3 * (2 * 64 + 2) + 8 * 7);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hub75_scan_driver_if #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC)) bus ();
    hub75_scan_driver #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC), .SHOW_BASE(SHOW_BASE)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    hub75_scan_driver_if #(.COLS(64), .ROWS(32), .BPC(3)) bus2 ();
    hub75_scan_driver #(.COLS(64), .ROWS(32), .BPC(3), .SHOW_BASE(8)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    logic [3*BPC-1:0] fb    [2][ROWS][COLS];
    bit               known [2][ROWS][COLS];
    int t, m_front, m_abc;
    bit started, m_pending;
    int checks = 0, failures = 0;
    int lat_cnt = 0, ack_cnt = 0, fd_cnt = 0, oe_low_cnt = 0;
    int cyc = 0, big_last = -1, big_checks = 0;

    function automatic int plane_len(input int b);
        return 2 * COLS + 2 + (SHOW_BASE << b);
    endfunction

    function automatic logic [2:0] chan_bits(input logic [3*BPC-1:0] px, input int b);
        logic [3*BPC-1:0] s;
        s = px >> b;
        return {s[2*BPC], s[BPC], s[0]};
    endfunction

    // One clock: check every panel output against the model, then advance the model
    // across the edge with the inputs currently applied.
    task automatic tick();
        int row, o, b, p;
        logic [5:0] e_rgb, mask;
        logic e_outclk, e_lat, e_oe, e_ack, e_fd;
        logic [10+AW:0] obs, expv;
        #1;
        e_rgb = '0; mask = 6'h3f; e_outclk = 0; e_lat = 0; e_oe = 1; e_ack = 0; e_fd = 0;
        if (started) begin
            row = t / ROW_LEN;
            o = t % ROW_LEN;
            b = 0;
            while (o >= plane_len(b)) begin
                o -= plane_len(b);
                b++;
            end
            if (o < 2 * COLS) begin
                p = o / 2;
                e_outclk = (o % 2) == 1;
                e_rgb = {chan_bits(fb[m_front][row][p], b), chan_bits(fb[m_front][row + HALF][p], b)};
                mask = {{3{known[m_front][row][p]}}, {3{known[m_front][row + HALF][p]}}};
            end else if (o == 2 * COLS) begin
                m_abc = row;
            end else if (o == 2 * COLS + 1) begin
                e_lat = 1;
            end else begin
                e_oe = bus.blank;
            end
            e_fd = (t == FRAME - 1);
            e_ack = e_fd && (m_pending || bus.swap_req);
        end
        obs  = {bus.rgb & mask, bus.outclk, bus.lat, bus.oe, bus.abc, bus.swap_ack, bus.frame_done};
        expv = {e_rgb & mask, e_outclk, e_lat, e_oe, m_abc[AW-1:0], e_ack, e_fd};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL panel t=%0d obs=%h exp=%h", t, obs, expv);
        end
        lat_cnt += int'(bus.lat);
        ack_cnt += int'(bus.swap_ack);
        fd_cnt += int'(bus.frame_done);
        oe_low_cnt += int'(!bus.oe);
        if (bus2.frame_done) begin
            if (big_last >= 0) begin
                checks++;
                big_checks++;
                assert ((cyc - big_last) === FRAME2) else begin
                    failures++;
                    $error("FAIL big_frame period=%0d exp=%0d", cyc - big_last, FRAME2);
                end
            end
            big_last = cyc;
        end
        if (reset) begin
            started = 0; t = 0; m_front = 0; m_pending = 0; m_abc = 0; big_last = -1;
        end else begin
            if (bus.wr_en && int'(bus.wr_x) < COLS && int'(bus.wr_y) < ROWS) begin
                fb[1 - m_front][bus.wr_y][bus.wr_x] = bus.wr_rgb;
                known[1 - m_front][bus.wr_y][bus.wr_x] = 1;
            end
            if (e_ack) m_front = 1 - m_front;
            m_pending = e_ack ? 1'b0 : (m_pending || bus.swap_req);
            if (!started) started = 1;
            else t = (t + 1) % FRAME;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (!(started && t == target) && n < 3 * FRAME) begin
            tick();
            n++;
        end
        if (!(started && t == target)) begin
            checks++;
            failures++;
            $error("FAIL run_to timeout target=%0d t=%0d", target, t);
        end
    endtask

    task automatic wr(input int x, input int y, input logic [3*BPC-1:0] v);
        bus.wr_en = 1; bus.wr_x = x[XW-1:0]; bus.wr_y = y[YW-1:0]; bus.wr_rgb = v;
        tick();
        bus.wr_en = 0;
    endtask

    task automatic do_swap();
        int a0 = ack_cnt;
        int n = 0;
        bus.swap_req = 1;
        tick();
        bus.swap_req = 0;
        while (ack_cnt == a0 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        checks++;
        assert (ack_cnt === a0 + 1) else begin
            failures++;
            $error("FAIL swap_ack count=%0d exp=%0d", ack_cnt - a0, 1);
        end
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        int a0, l0, f0, o0;
        bus.wr_en = 0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0; bus.swap_req = 0; bus.blank = 0;
        bus2.wr_en = 0; bus2.wr_x = '0; bus2.wr_y = '0; bus2.wr_rgb = '0; bus2.swap_req = 0; bus2.blank = 0;
        started = 0; t = 0; m_front = 0; m_pending = 0; m_abc = 0;
        for (int k = 0; k < 2; k++)
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++) begin
                    fb[k][y][x] = '0;
                    known[k][y][x] = 0;
                end
        reset = 1;
        @(posedge clk);
        #1;
        tick();
        reset = 0;

        // Clear back buffer, swap, clear the other, place two pixels, swap again.
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) wr(x, y, '0);
        do_swap();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) wr(x, y, '0);
        wr(0, 0, 6'b11_00_00);
        wr(31, 8, 6'b00_00_11);
        do_swap();
        chk("p0_first", bus.rgb, 6'b100_000);
        run_to(10);
        chk("p0_mid", bus.rgb, 6'b000_000);
        run_to(2 * COLS - 1);
        chk("p0_last", bus.rgb, 6'b000_001);
        run_to(PLANE0);
        chk("p1_first", bus.rgb, 6'b100_000);
        run_to(PLANE0 + 2 * COLS - 1);
        chk("p1_last", bus.rgb, 6'b000_001);

        // Free run: latch and frame_done counts over whole frames.
        run_to(0);
        l0 = lat_cnt; f0 = fd_cnt;
        run(2 * FRAME);
        chk_int("lat_per_2frames", lat_cnt - l0, 2 * HALF * BPC);
        chk_int("frame_done_per_2frames", fd_cnt - f0, 2);

        // Random writes and blank, with two swap requests in one frame.
        run_to(100);
        a0 = ack_cnt;
        bus.swap_req = 1;
        tick();
        bus.swap_req = 0;
        for (int i = 0; i < 900; i++) begin
            bus.wr_en = ($urandom_range(0, 3) != 0);
            bus.wr_x = XW'($urandom_range(0, COLS - 1));
            bus.wr_y = YW'($urandom_range(0, ROWS - 1));
            bus.wr_rgb = 6'($urandom);
            bus.blank = ($urandom_range(0, 7) == 0);
            bus.swap_req = (i == 600);
            tick();
        end
        bus.wr_en = 0; bus.swap_req = 0; bus.blank = 0;
        wr(COLS - 1, ROWS - 1, 6'b01_10_01);
        run_to(0);
        chk_int("double_req_acks", ack_cnt - a0, 1);
        run(FRAME);

        // Write on the swap cycle appears in the new front frame.
        bus.swap_req = 1;
        tick();
        bus.swap_req = 0;
        run_to(FRAME - 1);
        wr(5, 3, 6'b10_01_11);
        run_to(3 * ROW_LEN + 10);
        chk("coincident_p0", {bus.rgb[5:3], 3'b000}, 6'b011_000);
        run_to(3 * ROW_LEN + PLANE0 + 11);
        chk("coincident_p1", {bus.rgb[5:3], 3'b000}, 6'b101_000);

        // Blank for a whole frame.
        run_to(0);
        o0 = oe_low_cnt; l0 = lat_cnt;
        bus.blank = 1;
        run(FRAME);
        bus.blank = 0;
        chk_int("blank_oe_low", oe_low_cnt - o0, 0);
        chk_int("blank_lat", lat_cnt - l0, HALF * BPC);

        // Reset during SHOW of row 5 with a swap pending.
        bus.swap_req = 1;
        tick();
        bus.swap_req = 0;
        run_to(5 * ROW_LEN + 2 * COLS + 5);
        reset = 1;
        tick();
        reset = 0;
        checks++;
        assert ({bus.rgb, bus.outclk, bus.lat, bus.oe, bus.abc, bus.swap_ack, bus.frame_done}
                === {6'b0, 1'b0, 1'b0, 1'b1, AW'(0), 1'b0, 1'b0}) else begin
            failures++;
            $error("FAIL reset_values obs=%b", {bus.rgb, bus.outclk, bus.lat, bus.oe, bus.abc});
        end
        a0 = ack_cnt; f0 = fd_cnt;
        run(2 * FRAME + 1);
        chk_int("reset_drops_pending", ack_cnt - a0, 0);
        chk_int("reset_frames", fd_cnt - f0, 2);

        // Larger geometry: frame period of the second instance.
        begin
            int n = 0;
            while (big_checks < 2 && n < 4 * FRAME2) begin
                tick();
                n++;
            end
        end
        chk_int("big_periods_seen", big_checks >= 2 ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Parametrised HUB75 RGB LED-matrix scan driver with an internal double-buffered framebuffer and binary-coded-modulation colour depth. Game and menu logic write pixels into the back buffer and request a swap. The driver continuously scans the front buffer onto the panel, two scan lines at a time (top and bottom halves), producing `rgb`, `outclk`, `lat`, `oe` and `abc`. It succeeds the fixed 32x16, 1-bit-per-colour display modules: geometry and colour depth are now parameters, and the driver adds frame buffering, tear-free swapping and per-pixel intensity.

## Interface
- `COLS`, 32, panel columns (power of 2, ≥4)
- `ROWS`, 16, panel rows (power of 2, ≥4); scan lines = ROWS/2
- `BPC`, 2, bits per colour channel (1..4)
- `SHOW_BASE`, 8, display cycles for bit plane 0; plane b shows `SHOW_BASE<<b`
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `wr_en`  in  1  write one pixel to back buffer this cycle
- `wr_x`  in  clog2(COLS)  column
- `wr_y`  in  clog2(ROWS)  row (0 = top)
- `wr_rgb`  in  3*BPC  {R,G,B}, each BPC bits
- `swap_req`  in  1  request front/back swap at next frame end (pulse or level)
- `blank`  in  1  force panel dark (oe held 1); scanning continues
- `rgb`  out  6  {R1,G1,B1,R2,G2,B2}
- `outclk`  out  1  panel shift clock
- `lat`  out  1  latch strobe
- `oe`  out  1  output enable, active-low (1 = dark)
- `abc`  out  clog2(ROWS/2)  scan-line address
- `swap_ack`  out  1  one-cycle pulse when the swap takes effect
- `frame_done`  out  1  one-cycle pulse at end of each frame

## Operation
- Framebuffer: two buffers, each COLS×ROWS×3·BPC bits. Each buffer is banked top (y<ROWS/2) and bottom, so one synchronous read per bank serves a pixel pair. `front` selects the scanned buffer. Writes always target `~front`. Contents are not cleared by reset.
- Scan loop: for row r = 0..ROWS/2-1, then plane b = 0..BPC-1, then states SHIFT → BLANK → LATCH → SHOW.
  - SHIFT: 2·COLS cycles, counter c. Pixel p = c>>1, `outclk` = c[0].
    - `rgb` holds bit b of pixel (p, r) in R1G1B1 and bit b of (p, r+ROWS/2) in R2G2B2.
    - `rgb` is valid for both cycles of the pixel.
    - `oe`=1.
    - Read prefetch is internal; no bubbles.
  - BLANK: 1 cycle. `oe`=1, `outclk`=0, `rgb`=0, `abc`←r.
  - LATCH: 1 cycle. `lat`=1, `oe`=1.
  - SHOW: SHOW_BASE<<b cycles. `oe`=`blank`, `lat`=0.
- Transitions:
  - After SHOW, if b<BPC-1: b+1, back to SHIFT.
  - Otherwise b=0 and r+1.
  - After the last plane of row ROWS/2-1: r wraps to 0, `frame_done` pulses on the last SHOW cycle.
- Swap:
  - `swap_req` sets a sticky pending flag; repeat requests while pending have no effect.
  - On the `frame_done` cycle with pending (or `swap_req`) set: `front` toggles at that clock edge, `swap_ack` pulses in the same cycle, and pending clears.
  - The next frame scans the new front buffer.
- Writes:
  - A write with wr_x≥COLS or wr_y≥ROWS is ignored.
  - A write coincident with the swap edge lands in the pre-swap back buffer, which becomes the new front.
- `blank` affects only `oe`. Timing and `lat`/`abc` are unchanged.

## Timing
- Reset (synchronous): next edge gives `rgb`=0, `outclk`=0, `lat`=0, `oe`=1, `abc`=0, `swap_ack`=0, `frame_done`=0, state SHIFT, c=0, r=0, b=0, front=0, pending=0.
- Reset mid-frame aborts the scan immediately. Any pending swap is dropped.
- First valid `rgb` appears 1 cycle after reset deassertion (prefetch). This is the only latency allowance; c=0 of the first SHIFT starts on that cycle.
- Cycles per plane b: 2·COLS + 2 + (SHOW_BASE<<b).
- Defaults: plane 0 = 74, plane 1 = 82, row = 156, frame = 1248 cycles.
- `lat` and `outclk` are never high in the same cycle. `oe`=1 whenever `lat`=1 or `abc` changes.
- Write-to-visible latency: write, then swap, then the following frame start.

## Test plan
- Reset, back buffer all 0, swap. Then write pixel (0,0)=R3 G0 B0 and (31,8)=B3 and swap again. Required: `swap_ack` at a `frame_done`; in row 0, plane 0 and plane 1, first pixel `rgb`=100_000 and last pixel `rgb`=000_001; all other pixels 0.
- Free-run 2 frames with defaults. Required: `frame_done` period 1248; `abc` sequence 0..7; `lat` pulses exactly 16 per frame; SHOW lengths 8 and 16.
- `swap_req` pulsed mid-frame plus a second pulse before frame end. Required: exactly one `swap_ack`, coincident with `frame_done`; `front` toggles once.
- Write at wr_x=32 / wr_y=16, and a write on the swap cycle. Required: out-of-range writes have no effect; the coincident write appears in the new front frame.
- `blank`=1 for a whole frame. Required: `oe` stays 1 throughout; `lat`/`abc`/`outclk` timing is identical to the unblanked run.
- Reset asserted during SHOW of row 5. Required: next cycle shows all reset values; the scan restarts at r=0, b=0; a pending swap is cleared. Rerun with COLS=64, ROWS=32, BPC=3: frame = 16·(3·130 + 8 + 16 + 32) = 7136 cycles.
